// File: rtl/rpc2_ctrl_pkg.sv
// Shared definitions for the RPC2 controller AXI data paths:
// R-channel response codes, the burst FSM state type and the
// address-bit helper used to size low-address ports.
package rpc2_ctrl_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } burst_state_t;

    // Number of byte-offset bits inside one AXI data beat (32 -> 2, 64 -> 3).
    function automatic int addr_bits(input int dw);
        return (dw == 64) ? 3 : 2;
    endfunction

endpackage

// File: rtl/rpc2_ctrl_rd_pack.sv
// Read-data packer: merges narrow IP units into a beat-wide word at the
// running byte offset and pushes the finished beat, with its error flag,
// into the RDAT FIFO. Build option RPC2_RD_ERR_STICKY_EN keeps the error
// flag set for the rest of the burst once any unit reports an error.
module rpc2_ctrl_rd_pack
    import rpc2_ctrl_pkg::*;
#(
    parameter int DW = 32,
    parameter int AB = addr_bits(DW)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AB-1:0] start_addr,
    input  logic [1:0]    unit_size,
    input  logic [1:0]    beat_size,
    input  logic          active,
    input  logic          valid,
    input  logic [DW-1:0] data,
    input  logic          err,
    input  logic          full,
    output logic          ready,
    output logic          wr_en,
    output logic [DW:0]   din
);

    localparam int NB = DW / 8;

    logic [AB-1:0] offset;
    logic [DW-1:0] pack_data;
    logic          pack_err;
    logic          pending;

    logic [AB:0]   one;
    logic [AB:0]   unit_bytes;
    logic [AB:0]   unit_mask;
    logic [AB:0]   beat_mask;
    logic [AB:0]   lane_end;
    logic [AB-1:0] next_off;
    logic [AB-1:0] start_off;
    logic          boundary;
    logic [DW-1:0] merged;
    logic [AB:0]   lane_pos;

    // Unit/beat geometry; the start offset is the address aligned to the
    // unit size, so an unaligned start yields a partial first beat.
    always_comb begin
        one        = {{AB{1'b0}}, 1'b1};
        unit_bytes = one << unit_size;
        unit_mask  = unit_bytes - one;
        beat_mask  = (one << beat_size) - one;
        lane_end   = {1'b0, offset} + unit_bytes;
        next_off   = lane_end[AB-1:0];
        start_off  = start_addr & ~unit_mask[AB-1:0];
        boundary   = ((next_off & beat_mask[AB-1:0]) == '0);
    end

    // Overwrite only the byte lanes covered by the incoming unit.
    always_comb begin
        merged   = pack_data;
        lane_pos = '0;
        for (int i = 0; i < NB; i++) begin
            lane_pos = i[AB:0];
            if ((lane_pos >= {1'b0, offset}) && (lane_pos < lane_end))
                merged[8*i +: 8] = data[8*i +: 8];
        end
    end

    assign ready = active & ~pending;
    assign wr_en = pending & ~full;
    assign din   = {pack_err, pack_data};

    // Accept units, flag a finished beat, and clear it once pushed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            offset    <= '0;
            pack_data <= '0;
            pack_err  <= 1'b0;
            pending   <= 1'b0;
        end else if (start) begin
            offset    <= start_off;
            pack_data <= '0;
            pack_err  <= 1'b0;
            pending   <= 1'b0;
        end else if (wr_en) begin
            pending   <= 1'b0;
            pack_data <= '0;
`ifndef RPC2_RD_ERR_STICKY_EN
            pack_err  <= 1'b0;
`endif
        end else if (valid && ready) begin
            pack_data <= merged;
            pack_err  <= pack_err | err;
            offset    <= next_off;
            if (boundary)
                pending <= 1'b1;
        end
    end

endmodule

// File: rtl/rpc2_ctrl_axi_rd_data_control.sv
// AXI read-data control for the RPC2 controller: packs IP read units into
// the external show-ahead RDAT FIFO and pops it onto the AXI R channel.
// Optional build macro: RPC2_RD_ERR_STICKY_EN (sticky per-burst error).
//
// Handshakes: every transfer (IP unit, R beat) completes on a rising edge
// where valid and ready are both high; a valid source holds its payload
// stable until that edge.
module rpc2_ctrl_axi_rd_data_control
    import rpc2_ctrl_pkg::*;
#(
    parameter int C_AXI_ID_WIDTH       = 4,
    parameter int C_AXI_DATA_WIDTH     = 32,
    parameter int RDAT_FIFO_DATA_WIDTH = C_AXI_DATA_WIDTH + 1,
    localparam int AB                  = addr_bits(C_AXI_DATA_WIDTH)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            rready_req,
    input  logic [7:0]                      rready_len,
    input  logic [1:0]                      rready_size,
    input  logic [AB-1:0]                   rready_addr,
    input  logic [C_AXI_ID_WIDTH-1:0]       rready_id,
    output logic                            rready_done,
    input  logic [1:0]                      ip_data_size,
    input  logic                            ip2axi_data_valid,
    input  logic [C_AXI_DATA_WIDTH-1:0]     ip2axi_data,
    input  logic                            ip2axi_err,
    output logic                            axi2ip_data_ready,
    input  logic                            rdat_full,
    input  logic                            rdat_empty,
    input  logic [RDAT_FIFO_DATA_WIDTH-1:0] rdat_dout,
    output logic                            rdat_wr_en,
    output logic                            rdat_rd_en,
    output logic [RDAT_FIFO_DATA_WIDTH-1:0] rdat_din,
    output logic [C_AXI_ID_WIDTH-1:0]       AXI_RID,
    output logic [C_AXI_DATA_WIDTH-1:0]     AXI_RDATA,
    output logic [1:0]                      AXI_RRESP,
    output logic                            AXI_RLAST,
    output logic                            AXI_RVALID,
    input  logic                            AXI_RREADY,
    output burst_state_t                    dbg_state
);

    burst_state_t state;
    logic [7:0]   len_q;
    logic [1:0]   size_q;
    logic [8:0]   pop_cnt;
    logic         start;
    logic         r_hs;

    assign start       = rready_req & (state == IDLE);
    assign r_hs        = AXI_RVALID & AXI_RREADY;
    assign rready_done = r_hs & AXI_RLAST;
    assign dbg_state   = state;

    assign rdat_rd_en = ~rdat_empty & (state == BURST) & (~AXI_RVALID | AXI_RREADY)
                      & (pop_cnt <= {1'b0, len_q});

    rpc2_ctrl_rd_pack #(
        .DW (C_AXI_DATA_WIDTH),
        .AB (AB)
    ) u_pack (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (rready_addr),
        .unit_size  (ip_data_size),
        .beat_size  (size_q),
        .active     (state == BURST),
        .valid      (ip2axi_data_valid),
        .data       (ip2axi_data),
        .err        (ip2axi_err),
        .full       (rdat_full),
        .ready      (axi2ip_data_ready),
        .wr_en      (rdat_wr_en),
        .din        (rdat_din)
    );

    // Burst FSM plus the registered R-channel output stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            len_q      <= '0;
            size_q     <= '0;
            pop_cnt    <= '0;
            AXI_RID    <= '0;
            AXI_RDATA  <= '0;
            AXI_RRESP  <= RESP_OKAY;
            AXI_RLAST  <= 1'b0;
            AXI_RVALID <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rready_req) begin
                        state   <= BURST;
                        len_q   <= rready_len;
                        size_q  <= rready_size;
                        AXI_RID <= rready_id;
                        pop_cnt <= '0;
                    end
                end
                BURST: begin
                    if (r_hs && AXI_RLAST)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (rdat_rd_en) begin
                AXI_RDATA  <= rdat_dout[C_AXI_DATA_WIDTH-1:0];
                AXI_RRESP  <= rdat_dout[C_AXI_DATA_WIDTH] ? RESP_SLVERR : RESP_OKAY;
                AXI_RLAST  <= (pop_cnt == {1'b0, len_q});
                AXI_RVALID <= 1'b1;
                pop_cnt    <= pop_cnt + 9'd1;
            end else if (r_hs) begin
                AXI_RVALID <= 1'b0;
            end
        end
    end

endmodule
